// File: rtl/pulse_stretch_if.sv
// Signal bundle between a strobe source and the pulse stretcher.
// trig is a one-cycle request; out/busy/dropped/state_dbg are registered status from the stretcher.
interface pulse_stretch_if;
   logic       trig;
   logic       out;
   logic       busy;
   logic       dropped;
   logic [1:0] state_dbg;

   modport master (output trig, input out, input busy, input dropped, input state_dbg);
   modport slave  (input trig, output out, output busy, output dropped, output state_dbg);
endinterface

// File: rtl/pulse_stretch.sv
// Turns a single-cycle strobe into a fixed-width, glitch-free level pulse on an external line,
// with a minimum recovery gap, a one-deep trigger queue and a drop flag.
module pulse_stretch #(
   parameter int CNT_W          = 16,
   parameter int ACTIVE_LEN     = 50000,
   parameter int GAP_LEN        = 5000,
   parameter bit OUT_ACTIVE_LOW = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   pulse_stretch_if.slave  ps
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACTIVE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
   localparam bit   HAS_GAP  = (GAP_LEN > 0);
   localparam logic LVL_ON   = ~OUT_ACTIVE_LOW;
   localparam logic LVL_OFF  = OUT_ACTIVE_LOW;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             pend, pend_nx;
   logic             drop_nx;
   logic             end_gap;
   logic             queue_ok;
   logic             cnt_last;
   logic             out_q, busy_q, dropped_q;

   assign cnt_last = (cnt == '0);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = pend;
      drop_nx  = 1'b0;
      end_gap  = 1'b0;
      queue_ok = 1'b0;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (ps.trig) begin
               state_nx = ACTIVE;
               cnt_nx   = ACT_LOAD;
            end
         end
         ACTIVE: begin
            // With no gap configured the last active cycle is also the end-of-gap decision point.
            if (cnt_last && !HAS_GAP) begin
               end_gap = 1'b1;
            end else if (cnt_last) begin
               state_nx = GAP;
               cnt_nx   = GAP_LOAD;
               queue_ok = 1'b1;
            end else begin
               cnt_nx   = cnt - CNT_W'(1);
               queue_ok = 1'b1;
            end
         end
         GAP: begin
            if (cnt_last) begin
               end_gap = 1'b1;
            end else begin
               cnt_nx   = cnt - CNT_W'(1);
               queue_ok = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            pend_nx  = 1'b0;
         end
      endcase

      // A queued request wins the restart; a trig arriving at that moment takes its queue slot.
      if (end_gap) begin
         if (pend) begin
            state_nx = ACTIVE;
            cnt_nx   = ACT_LOAD;
            pend_nx  = ps.trig;
         end else if (ps.trig) begin
            state_nx = ACTIVE;
            cnt_nx   = ACT_LOAD;
         end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      end

      if (queue_ok && ps.trig) begin
         if (pend) drop_nx = 1'b1;
         else      pend_nx = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         pend      <= 1'b0;
         out_q     <= LVL_OFF;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         pend      <= pend_nx;
         out_q     <= (state_nx == ACTIVE) ? LVL_ON : LVL_OFF;
         busy_q    <= (state_nx != IDLE) | pend_nx;
         dropped_q <= drop_nx;
      end
   end

   assign ps.out       = out_q;
   assign ps.busy      = busy_q;
   assign ps.dropped   = dropped_q;
   assign ps.state_dbg = state;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: two configurations share one trig stream and are checked each cycle
// against a schedule model (pulse start edge, fixed active/gap windows, one pending slot).
module tb_pulse_stretch;

   logic clk;
   logic reset_n;
   logic trig;

   pulse_stretch_if ifa ();
   pulse_stretch_if ifb ();

   assign ifa.trig = trig;
   assign ifb.trig = trig;

   pulse_stretch #(
      .CNT_W(16), .ACTIVE_LEN(4), .GAP_LEN(2), .OUT_ACTIVE_LOW(1'b1)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .ps(ifa.slave)
   );

   pulse_stretch #(
      .CNT_W(2), .ACTIVE_LEN(3), .GAP_LEN(0), .OUT_ACTIVE_LOW(1'b0)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .ps(ifb.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: a pulse decided at edge d is asserted after edges d..d+A-1,
   // its final gap cycle is sampled at edge d+A+G.
   int     m_a   [2] = '{4, 3};
   int     m_g   [2] = '{2, 0};
   bit     m_oal [2] = '{1'b1, 1'b0};
   bit     m_act [2];
   bit     m_pend[2];
   bit     m_drop[2];
   longint m_d   [2];
   bit     e_out [2];
   longint edge_n = 0;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_act[i]  = 1'b0;
         m_pend[i] = 1'b0;
         m_drop[i] = 1'b0;
         e_out[i]  = m_oal[i];
      end
   endtask

   task automatic model_edge(input bit t);
      for (int i = 0; i < 2; i++) begin
         m_drop[i] = 1'b0;
         if (!m_act[i]) begin
            if (t) begin
               m_act[i] = 1'b1;
               m_d[i]   = edge_n;
            end
         end else if (edge_n == m_d[i] + m_a[i] + m_g[i]) begin
            if (m_pend[i]) begin
               m_d[i]    = edge_n;
               m_pend[i] = t;
            end else if (t) begin
               m_d[i] = edge_n;
            end else begin
               m_act[i] = 1'b0;
            end
         end else if (t) begin
            if (m_pend[i]) m_drop[i] = 1'b1;
            else           m_pend[i] = 1'b1;
         end
         e_out[i] = (m_act[i] && (edge_n - m_d[i]) < m_a[i]) ? ~m_oal[i] : m_oal[i];
      end
      edge_n++;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_out_a"},  ifa.out,     e_out[0]);
      check({tag, "_busy_a"}, ifa.busy,    m_act[0]);
      check({tag, "_drop_a"}, ifa.dropped, m_drop[0]);
      check({tag, "_out_b"},  ifb.out,     e_out[1]);
      check({tag, "_busy_b"}, ifb.busy,    m_act[1]);
      check({tag, "_drop_b"}, ifb.dropped, m_drop[1]);
   endtask

   // driver tasks: trig changes at negedge, DUT samples it at posedge, outputs checked at next negedge
   task automatic cycle(input bit t, input string tag);
      trig = t;
      @(posedge clk);
      if (reset_n) model_edge(t);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic async_reset(input int ncyc, input string tag);
      trig    = 1'b0;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all({tag, "_async"});
      repeat (ncyc) begin
         @(posedge clk);
         @(negedge clk);
         check_all({tag, "_hold"});
      end
      reset_n = 1'b1;
   endtask

   task automatic run_seq(input logic [31:0] pat, input int len, input string tag);
      for (int i = 0; i < len; i++) cycle(pat[i], tag);
   endtask

   initial begin
      reset_n = 1'b1;
      trig    = 1'b0;
      #2;
      async_reset(5, "s1_rst");
      repeat (20) cycle(1'b0, "s1_idle");

      run_seq(32'h0000_0001, 12, "s2_single");
      run_seq(32'h0000_0005, 16, "s3_queue");
      run_seq(32'h0000_000D, 16, "s4_drop");
      run_seq(32'h0000_0041, 16, "s5_final_gap");
      run_seq(32'h0000_0047, 20, "s5_pend_final");

      // trig at k and k+2, then reset during cycle k+3
      run_seq(32'h0000_0005, 3, "s6_pre");
      async_reset(2, "s6_rst");
      repeat (10) cycle(1'b0, "s6_wait");
      run_seq(32'h0000_0001, 12, "s6_fresh");

      for (int blk = 0; blk < 15; blk++) begin
         int p;
         p = $urandom_range(5, 70);
         for (int c = 0; c < 200; c++) cycle($urandom_range(0, 99) < p, "rnd");
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk);
            #2;
            async_reset($urandom_range(1, 3), "rnd_rst");
            @(negedge clk);
         end
      end

      repeat (20) cycle(1'b0, "drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
